// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header
//
// Strips a per-packet header of 1..DATA_BYTE_WD bytes off the front of an
// AXI-Stream packet. The header appears right-aligned on the header port;
// the remaining payload is realigned to byte lane 0 and forwarded at one
// beat per cycle.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   valid_strip/byte_strip_cnt/ready_strip  per-packet header length (bytes)
//   valid_in/data_in/keep_in/last_in/ready_in   input stream
//   valid_hdr/data_hdr/keep_hdr/ready_hdr       extracted header
//   valid_out/data_out/keep_out/last_out/ready_out  realigned payload
//
// Byte 0 of a beat sits in data[DATA_WD-1 -: 8] and is qualified by
// keep[DATA_BYTE_WD-1].
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CFG   | waiting for the header length of the next packet
// S_FIRST | waiting for the first beat; header captured from it
// S_BODY  | realigning payload beats using the carried residue
// S_FLUSH | emitting the leftover residue as the final payload beat

module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      valid_strip,
  input  logic [BYTE_CNT_WD:0]      byte_strip_cnt,
  output logic                      ready_strip,

  input  logic                      valid_in,
  input  logic [DATA_WD-1:0]        data_in,
  input  logic [DATA_BYTE_WD-1:0]   keep_in,
  input  logic                      last_in,
  output logic                      ready_in,

  output logic                      valid_hdr,
  output logic [DATA_WD-1:0]        data_hdr,
  output logic [DATA_BYTE_WD-1:0]   keep_hdr,
  input  logic                      ready_hdr,

  output logic                      valid_out,
  output logic [DATA_WD-1:0]        data_out,
  output logic [DATA_BYTE_WD-1:0]   keep_out,
  output logic                      last_out,
  input  logic                      ready_out
);

  localparam int CW = BYTE_CNT_WD + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;
  localparam cnt_t FULL_CNT = cnt_t'(DATA_BYTE_WD);
  localparam logic [DATA_BYTE_WD-1:0] ALL_KEEP = '1;

  typedef enum logic [1:0] {S_CFG, S_FIRST, S_BODY, S_FLUSH} state_t;

  function automatic cnt_t popcnt(input logic [DATA_BYTE_WD-1:0] k);
    cnt_t c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + cnt_t'(k[i]);
    return c;
  endfunction

  // Keep mask covering the first n stream bytes.
  function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input cnt_t n);
    return ALL_KEEP << (FULL_CNT - n);
  endfunction

  function automatic logic [DATA_WD-1:0] bit_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t             state;
  cnt_t               hdr_cnt;
  cnt_t               res_cnt;
  logic [DATA_WD-1:0] res_data;

  logic               out_free;
  logic               in_fire;
  logic               strip_fire;
  cnt_t               in_cnt;
  cnt_t               hdr_shift;
  cnt_t               body_res_shift;
  sum_t               body_sum;
  logic               body_fits;
  cnt_t               body_last_cnt;
  logic [DATA_WD-1:0] first_hdr;
  logic [DATA_WD-1:0] first_res;
  logic [DATA_WD-1:0] body_out;
  logic [DATA_WD-1:0] body_res;

  // Readies depend only on state and register occupancy (plus the downstream
  // ready), never on any incoming valid.
  assign out_free    = !valid_out || ready_out;
  assign ready_strip = (state == S_CFG);

  always_comb begin
    ready_in = 1'b0;
    case (state)
      S_FIRST: ready_in = !valid_hdr;
      S_BODY:  ready_in = out_free;
      default: ready_in = 1'b0;
    endcase
  end

  assign in_fire    = valid_in && ready_in;
  assign strip_fire = valid_strip && ready_strip;
  assign in_cnt     = popcnt(keep_in);

  // Residues are always kept MSB-aligned with zeros below, so the body beat is
  // a simple OR of the residue and the shifted-down input.
  assign hdr_shift      = FULL_CNT - hdr_cnt;
  assign first_hdr      = data_in >> {hdr_shift, 3'b000};
  assign first_res      = data_in << {hdr_cnt, 3'b000};
  assign body_out       = res_data | (data_in >> {res_cnt, 3'b000});
  assign body_res_shift = FULL_CNT - res_cnt;
  assign body_res       = data_in << {body_res_shift, 3'b000};
  assign body_sum       = {1'b0, res_cnt} + {1'b0, in_cnt};
  assign body_fits      = (body_sum <= {1'b0, FULL_CNT});
  assign body_last_cnt  = cnt_t'(body_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CFG;
      hdr_cnt   <= '0;
      res_cnt   <= '0;
      res_data  <= '0;
      valid_hdr <= 1'b0;
      data_hdr  <= '0;
      keep_hdr  <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;
      if (valid_out && ready_out) valid_out <= 1'b0;

      case (state)
        S_CFG: begin
          if (strip_fire) begin
            hdr_cnt <= byte_strip_cnt;
            state   <= S_FIRST;
          end
        end

        S_FIRST: begin
          if (in_fire) begin
            valid_hdr <= 1'b1;
            data_hdr  <= first_hdr;
            keep_hdr  <= ALL_KEEP >> hdr_shift;
            res_data  <= first_res;
            if (last_in) begin
              if (in_cnt > hdr_cnt) begin
                res_cnt <= in_cnt - hdr_cnt;
                state   <= S_FLUSH;
              end else begin
                state   <= S_CFG;
              end
            end else begin
              res_cnt <= hdr_shift;
              state   <= S_BODY;
            end
          end
        end

        S_BODY: begin
          if (in_fire) begin
            valid_out <= 1'b1;
            if (last_in && body_fits) begin
              data_out <= body_out & bit_mask(msb_mask(body_last_cnt));
              keep_out <= msb_mask(body_last_cnt);
              last_out <= 1'b1;
              state    <= S_CFG;
            end else begin
              data_out <= body_out;
              keep_out <= ALL_KEEP;
              last_out <= 1'b0;
              res_data <= body_res;
              if (last_in) begin
                res_cnt <= cnt_t'(body_sum - {1'b0, FULL_CNT});
                state   <= S_FLUSH;
              end
            end
          end
        end

        S_FLUSH: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= res_data & bit_mask(msb_mask(res_cnt));
            keep_out  <= msb_mask(res_cnt);
            last_out  <= 1'b1;
            state     <= S_CFG;
          end
        end

        default: state <= S_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
module tb_axi_stream_extract_header;

  localparam int DW  = 32;
  localparam int DBW = DW / 8;
  localparam int CW  = $clog2(DBW) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_strip;
  logic [CW-1:0]   byte_strip_cnt;
  logic            ready_strip;
  logic            valid_in;
  logic [DW-1:0]   data_in;
  logic [DBW-1:0]  keep_in;
  logic            last_in;
  logic            ready_in;
  logic            valid_hdr;
  logic [DW-1:0]   data_hdr;
  logic [DBW-1:0]  keep_hdr;
  logic            ready_hdr;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [DBW-1:0]  keep_out;
  logic            last_out;
  logic            ready_out;

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_strip    (valid_strip),
    .byte_strip_cnt (byte_strip_cnt),
    .ready_strip    (ready_strip),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_hdr      (valid_hdr),
    .data_hdr       (data_hdr),
    .keep_hdr       (keep_hdr),
    .ready_hdr      (ready_hdr),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  d;
    logic [DBW-1:0] k;
    logic           l;
  } beat_t;

  beat_t pkt[$];
  beat_t exp_pay[$];
  beat_t exp_hdr[$];

  int n_cmp = 0;
  int n_err = 0;
  bit abort_mode = 0;
  bit in_first = 0;
  int bp_mode = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bytes_mask(input logic [DBW-1:0] k);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < DBW; i++) if (k[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic beat_t mk(input logic [DW-1:0] d, input logic [DBW-1:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    return b;
  endfunction

  // Reference: flatten the packet to a byte list, take the first cnt bytes of
  // the first beat as the header, repack the remaining bytes from lane 0.
  task automatic model_push(input int cnt);
    logic [7:0]     bytes[$];
    logic [7:0]     first[$];
    logic [DBW-1:0] ones;
    beat_t          h;
    beat_t          b;
    ones = '1;
    for (int i = 0; i < pkt.size(); i++)
      for (int j = 0; j < DBW; j++) begin
        if (i == 0) first.push_back(pkt[i].d[DW-8-8*j +: 8]);
        if (pkt[i].k[DBW-1-j]) bytes.push_back(pkt[i].d[DW-8-8*j +: 8]);
      end
    h.d = '0;
    for (int i = 0; i < cnt; i++) h.d = {h.d[DW-9:0], first[i]};
    h.k = ones >> (DBW - cnt);
    h.l = 1'b0;
    exp_hdr.push_back(h);
    for (int p = cnt; p < bytes.size(); p += DBW) begin
      b.d = '0; b.k = '0;
      for (int j = 0; j < DBW; j++)
        if (p + j < bytes.size()) begin
          b.d[DW-8-8*j +: 8] = bytes[p+j];
          b.k[DBW-1-j] = 1'b1;
        end
      b.l = (p + DBW >= bytes.size());
      exp_pay.push_back(b);
    end
  endtask

  task automatic send_pkt(input int cnt, input bit push, input int gap_pct, input int stop_after);
    int  t;
    bit  fired;
    if (push) model_push(cnt);
    valid_strip = 1'b1;
    byte_strip_cnt = CW'(cnt);
    t = 0; fired = 0;
    while (!fired && t < 200) begin
      @(negedge clk); fired = ready_strip;
      @(posedge clk); #1; t++;
    end
    valid_strip = 1'b0;
    check("strip_handshake", DW'(fired), DW'(1));
    if (!fired) return;
    for (int i = 0; i < pkt.size() && i < stop_after; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      valid_in = 1'b1; data_in = pkt[i].d; keep_in = pkt[i].k; last_in = pkt[i].l;
      in_first = (i == 0);
      t = 0; fired = 0;
      while (!fired && t < 200) begin
        @(negedge clk); fired = ready_in;
        @(posedge clk); #1; t++;
      end
      valid_in = 1'b0; in_first = 1'b0;
      if (!fired) begin
        check("beat_handshake", DW'(fired), DW'(1));
        return;
      end
    end
  endtask

  task automatic rand_pkt(input int nb);
    logic [DBW-1:0] ones;
    ones = '1;
    pkt.delete();
    for (int i = 0; i < nb; i++)
      if (i == nb - 1) pkt.push_back(mk($urandom, ones << (DBW - $urandom_range(1, DBW)), 1'b1));
      else             pkt.push_back(mk($urandom, ones, 1'b0));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < 2000) begin
      @(posedge clk); t++;
    end
    #1;
    check("drain_payload", DW'(exp_pay.size()), DW'(0));
    check("drain_header", DW'(exp_hdr.size()), DW'(0));
    exp_pay.delete(); exp_hdr.delete();
  endtask

  // Downstream ready generation.
  initial begin
    int cyc;
    int prev;
    cyc = 0; prev = -1;
    ready_out = 1'b1; ready_hdr = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode != prev) cyc = 0; else cyc++;
      prev = bp_mode;
      case (bp_mode)
        1: begin
          ready_out = 1'($urandom_range(1));
          ready_hdr = ($urandom_range(3) != 0);
        end
        2: begin
          ready_out = ((cyc % 2) == 0);
          ready_hdr = (cyc >= 5);
        end
        default: begin
          ready_out = 1'b1; ready_hdr = 1'b1;
        end
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, header blocking.
  initial begin
    bit            pst_o, pst_h;
    beat_t         so, sh, e;
    pst_o = 0; pst_h = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pst_o = 0; pst_h = 0;
      end else begin
        if (pst_o) begin
          check("stall_valid_out", DW'(valid_out), DW'(1));
          check("stall_data_out", data_out, so.d);
          check("stall_keep_out", DW'(keep_out), DW'(so.k));
          check("stall_last_out", DW'(last_out), DW'(so.l));
        end
        if (pst_h) begin
          check("stall_valid_hdr", DW'(valid_hdr), DW'(1));
          check("stall_data_hdr", data_hdr, sh.d);
          check("stall_keep_hdr", DW'(keep_hdr), DW'(sh.k));
        end
        if (valid_out && ready_out) begin
          if (abort_mode) check("abort_no_last", DW'(last_out), DW'(0));
          else if (exp_pay.size() == 0) check("unexpected_payload", DW'(1), DW'(0));
          else begin
            e = exp_pay.pop_front();
            check("payload_data", data_out & bytes_mask(e.k), e.d);
            check("payload_keep", DW'(keep_out), DW'(e.k));
            check("payload_last", DW'(last_out), DW'(e.l));
          end
        end
        if (valid_hdr && ready_hdr && !abort_mode) begin
          if (exp_hdr.size() == 0) check("unexpected_header", DW'(1), DW'(0));
          else begin
            e = exp_hdr.pop_front();
            check("header_data", data_hdr, e.d);
            check("header_keep", DW'(keep_hdr), DW'(e.k));
          end
        end
        if (valid_in && in_first && valid_hdr) check("hdr_blocks_first", DW'(ready_in), DW'(0));
        pst_o = valid_out && !ready_out;
        so.d = data_out; so.k = keep_out; so.l = last_out;
        pst_h = valid_hdr && !ready_hdr;
        sh.d = data_hdr; sh.k = keep_hdr; sh.l = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid_strip = 1'b0; byte_strip_cnt = '0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", DW'(valid_out), DW'(0));
    check("rst_valid_hdr", DW'(valid_hdr), DW'(0));
    check("rst_last_out", DW'(last_out), DW'(0));
    check("rst_data_out", data_out, DW'(0));
    check("rst_data_hdr", data_hdr, DW'(0));
    check("rst_ready_strip", DW'(ready_strip), DW'(1));
    check("rst_ready_in", DW'(ready_in), DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, no stalls.
    pkt.delete();
    pkt.push_back(mk(32'hAABBCCDD, 4'hF, 1'b0));
    pkt.push_back(mk(32'h11223344, 4'hF, 1'b0));
    pkt.push_back(mk(32'h55667788, 4'hC, 1'b1));
    send_pkt(1, 1, 0, 99);
    pkt.delete();
    pkt.push_back(mk(32'h01020304, 4'hF, 1'b0));
    pkt.push_back(mk(32'h05060708, 4'hF, 1'b0));
    pkt.push_back(mk(32'h090A0B0C, 4'hE, 1'b1));
    send_pkt(4, 1, 0, 99);
    pkt.delete();
    pkt.push_back(mk(32'hDEADBEEF, 4'hF, 1'b1));
    send_pkt(2, 1, 0, 99);
    pkt.delete();
    pkt.push_back(mk(32'hDEADBEEF, 4'hE, 1'b1));
    send_pkt(3, 1, 0, 99);
    drain();

    // Backpressure: alternating ready_out, header port stalled 5 cycles.
    bp_mode = 2;
    pkt.delete();
    pkt.push_back(mk(32'hAABBCCDD, 4'hF, 1'b0));
    pkt.push_back(mk(32'h11223344, 4'hF, 1'b0));
    pkt.push_back(mk(32'h55667788, 4'hC, 1'b1));
    send_pkt(1, 1, 0, 99);
    pkt.delete();
    pkt.push_back(mk(32'h01020304, 4'hF, 1'b0));
    pkt.push_back(mk(32'h05060708, 4'hF, 1'b0));
    pkt.push_back(mk(32'h090A0B0C, 4'hE, 1'b1));
    send_pkt(4, 1, 0, 99);
    drain();

    // Random packets with random stalls on both sides.
    bp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      rand_pkt($urandom_range(1, 5));
      send_pkt($urandom_range(1, DBW), 1, 20, 99);
    end
    drain();
    bp_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a 6-beat packet.
    abort_mode = 1;
    rand_pkt(6);
    send_pkt(2, 0, 0, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", DW'(valid_out), DW'(0));
    check("midrst_valid_hdr", DW'(valid_hdr), DW'(0));
    check("midrst_last_out", DW'(last_out), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_valid_out", DW'(valid_out), DW'(0));
    check("midrst_ready_strip", DW'(ready_strip), DW'(1));
    rst_n = 1'b1;
    abort_mode = 0;
    @(posedge clk); #1;
    rand_pkt(3);
    send_pkt(2, 1, 0, 99);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

Receive-side counterpart of the header-insertion stage; sits directly downstream of it on the AXI-Stream path. Per packet, it takes a header length, peels the first 1..DATA_BYTE_WD bytes of the packet off onto a header port, and forwards the remaining payload realigned to byte lane 0. Handshakes on all ports are valid/ready, and one payload beat per cycle is sustained.

## Interface
- DATA_WD, 32, stream data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width; count ports are BYTE_CNT_WD+1 wide
- Clocking/reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_strip  in  1  header-length valid
- byte_strip_cnt  in  BYTE_CNT_WD+1  header length in bytes; legal 1..DATA_BYTE_WD
- ready_strip  out  1  length accepted when valid_strip && ready_strip
- valid_in / data_in / keep_in / last_in  in  1/DATA_WD/DATA_BYTE_WD/1  input stream
- ready_in  out  1  input ready
- valid_hdr / data_hdr / keep_hdr  out  1/DATA_WD/DATA_BYTE_WD  extracted header, right-aligned
- ready_hdr  in  1  header consumer ready
- valid_out / data_out / keep_out / last_out  out  1/DATA_WD/DATA_BYTE_WD/1  payload stream
- ready_out  in  1  payload consumer ready

## Operation
- Byte order: stream byte 0 = data[DATA_WD-1 -: 8] = keep[DATA_BYTE_WD-1]. Non-last input beats carry all-ones keep. The last beat's keep is MSB-contiguous and non-zero. Violations are undefined.
- The header is right-aligned: data_hdr holds its cnt bytes in the low lanes, upper lanes are 0, and keep_hdr = {DATA_BYTE_WD{1}} >> (DATA_BYTE_WD-cnt).
- State machine:
  - CFG: ready_strip=1, ready_in=0. On the length handshake, latch cnt and go to FIRST.
  - FIRST: ready_in = !valid_hdr. On an accepted beat:
    - Load the header register and set valid_hdr.
    - The remaining DATA_BYTE_WD-cnt bytes become the residue (r bytes, MSB-aligned).
    - If last_in: k = popcount(keep_in) - cnt. If k ≤ 0 (header-only packet), emit no payload and go to CFG. Otherwise go to FLUSH with r = k.
    - If not last: go to BODY.
  - BODY: ready_in = !valid_out || ready_out. On an accepted beat with k valid bytes:
    - Output {residue r bytes, first DATA_BYTE_WD-r bytes of data_in}. The new residue is the last r bytes of data_in. When r = 0 this is passthrough.
    - On last_in with r+k ≤ DATA_BYTE_WD: the output beat is last, keep_out = MSB mask of r+k, go to CFG.
    - On last_in with r+k > DATA_BYTE_WD: the output beat is full and not last, residue = r+k-DATA_BYTE_WD bytes, go to FLUSH.
  - FLUSH: when the output register is free, emit the residue zero-padded with MSB-mask keep and last_out=1, then go to CFG.
- valid_hdr clears on ready_hdr. valid_out clears on ready_out unless it is reloaded in the same cycle.

## Timing
- Reset values: valid_hdr=0, valid_out=0, last_out=0, data/keep outputs 0, state CFG. ready_strip=1 and ready_in=0 combinationally from state.
- ready_strip and ready_in are combinational from state and register occupancy. There is no combinational path from any valid input to any ready output.
- Payload latency: accepted input beat → valid_out on the next cycle. Header latency: FIRST-beat accept → valid_hdr on the next cycle.
- Throughput: 1 beat/cycle in BODY. There is a 1-cycle bubble per packet for the CFG handshake, plus 1 extra output beat when a FLUSH occurs.
- Under stall, all output data, keep and last signals hold stable while valid && !ready.
- A header from a previous packet that is not yet consumed blocks FIRST, which deasserts ready_in. Payload is never blocked by the header port outside FIRST.
- Reset mid-packet: all state is dropped immediately, no last_out is emitted, and the block resumes in CFG.

## Test plan
- cnt=1; input 0xAABBCCDD, 0x11223344, last 0x55667788 keep 1100.
  - Header: 0x000000AA, keep 0001.
  - Payload: 0xBBCCDD11 (f), 0x22334455 (f), then 0x66000000 keep 1000 last.
- cnt=4; input 0x01020304, 0x05060708, last 0x090A0B0C keep 1110.
  - Header: 0x01020304, keep f.
  - Payload: 0x05060708 (f), then 0x090A0B0C keep 1110 last, i.e. exact passthrough.
- Single-beat packets, input 0xDEADBEEF:
  - cnt=2, keep 1111 last → header 0x0000DEAD keep 0011; payload 0xBEEF0000 keep 1100 last.
  - cnt=3, keep 1110 last → header 0x00DEADBE keep 0111; no payload beat.
- Backpressure: ready_out toggles 1,0,1,0 and ready_hdr is held low 5 cycles over two back-to-back packets. The required response:
  - Payload byte sequence identical to the unstalled run.
  - Outputs stable during stalls.
  - The second packet's first beat is not accepted until the first header has been taken.
- Assert rst_n low during BODY of a 6-beat packet, then run a cnt=2 packet.
  - All valids are 0 during reset and no last_out is produced for the aborted packet.
  - The new packet extracts correctly.
